bram_loader: RTL

Upstream feeder for `BRAM_CTRL` in the ASIC tester.
- Consumes a 32-bit host word stream with a valid/ready handshake.
- Decodes command headers and assembles payload words into 128-bit records.
- Issues one write strobe per record to `BRAM_CTRL` and waits on its `READY` before starting the next record.
- Supported record types: input vectors, templates, FF pairs, cycle (TC) vectors.

---
 rtl/bram_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bram_loader.sv
// bram_loader: decodes host command headers, assembles 32-bit payload words into 128-bit records
// and issues one write strobe per record to BRAM_CTRL. Trailer checksum: define BRAM_LOADER_CKSUM_EN.
module bram_loader #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      HOST_DATA,
    input  logic             HOST_VALID,
    output logic             HOST_READY,
    output logic             INPUT_WRITE,
    output logic             TEMPLATE_WRITE,
    output logic             FF_WRITE,
    output logic             TC_WRITE,
    output logic [127:0]     WRITE_DATA_0,
    output logic [127:0]     WRITE_DATA_1,
    input  logic             BRAM_READY,
    output logic             BUSY,
    output logic             ERROR,
    output logic [CNT_W-1:0] CMD_COUNT
);

    localparam logic [3:0] OP_INPUT    = 4'd1;
    localparam logic [3:0] OP_TEMPLATE = 4'd2;
    localparam logic [3:0] OP_FF       = 4'd3;
    localparam logic [3:0] OP_TC       = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_STROBE,
        S_GUARD,
        S_WAIT_RDY,
        S_CKSUM
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [2:0]         word_cnt_q;
    logic [15:0]        rec_cnt_q;
    logic [127:0]       data0_q;
    logic [127:0]       data1_q;
    logic               error_q;
    logic [CNT_W-1:0]   cmd_cnt_q;
`ifdef BRAM_LOADER_CKSUM_EN
    logic [31:0]        cksum_q;
`endif

    logic               accept;
    logic [3:0]         hdr_op;
    logic               hdr_legal;

    assign hdr_op    = HOST_DATA[31:28];
    assign hdr_legal = (hdr_op >= OP_INPUT) && (hdr_op <= OP_TC);
    assign accept    = HOST_VALID && HOST_READY;

    // Word counter counts down to zero; the terminal value marks the last word of a record.
    function automatic logic [2:0] last_word_idx(input logic [3:0] op);
        return (op == OP_FF) ? 3'd7 : 3'd3;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            word_cnt_q <= '0;
            rec_cnt_q  <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            error_q    <= 1'b0;
            cmd_cnt_q  <= '0;
`ifdef BRAM_LOADER_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (hdr_legal) begin
                            op_q       <= hdr_op;
                            rec_cnt_q  <= HOST_DATA[15:0];
                            word_cnt_q <= last_word_idx(hdr_op);
`ifdef BRAM_LOADER_CKSUM_EN
                            cksum_q    <= '0;
                            state_q    <= (HOST_DATA[15:0] == 16'd0) ? S_CKSUM : S_COLLECT;
`else
                            if (HOST_DATA[15:0] == 16'd0) begin
                                cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
                            end else begin
                                state_q <= S_COLLECT;
                            end
`endif
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (accept) begin
                        if (op_q == OP_FF) begin
                            {data0_q, data1_q} <= {data0_q[95:0], data1_q, HOST_DATA};
                        end else begin
                            data0_q <= {data0_q[95:0], HOST_DATA};
                        end
`ifdef BRAM_LOADER_CKSUM_EN
                        cksum_q <= cksum_q ^ HOST_DATA;
`endif
                        word_cnt_q <= word_cnt_q - 3'd1;
                        if (word_cnt_q == 3'd0) begin
                            state_q <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (BRAM_READY) begin
                        state_q <= S_STROBE;
                    end
                end

                S_STROBE: state_q <= S_GUARD;

                // BRAM_CTRL may still report READY from before the strobe; skip one cycle.
                S_GUARD: state_q <= S_WAIT_RDY;

                S_WAIT_RDY: begin
                    if (BRAM_READY) begin
                        rec_cnt_q <= rec_cnt_q - 16'd1;
                        if (rec_cnt_q == 16'd1) begin
`ifdef BRAM_LOADER_CKSUM_EN
                            state_q   <= S_CKSUM;
`else
                            cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
                            state_q   <= S_IDLE;
`endif
                        end else begin
                            word_cnt_q <= last_word_idx(op_q);
                            state_q    <= S_COLLECT;
                        end
                    end
                end

`ifdef BRAM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (accept) begin
                        if (HOST_DATA == cksum_q) begin
                            cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
`endif

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign HOST_READY     = (state_q == S_IDLE) || (state_q == S_COLLECT) || (state_q == S_CKSUM);
    assign BUSY           = (state_q != S_IDLE);
    assign INPUT_WRITE    = (state_q == S_STROBE) && (op_q == OP_INPUT);
    assign TEMPLATE_WRITE = (state_q == S_STROBE) && (op_q == OP_TEMPLATE);
    assign FF_WRITE       = (state_q == S_STROBE) && (op_q == OP_FF);
    assign TC_WRITE       = (state_q == S_STROBE) && (op_q == OP_TC);
    assign WRITE_DATA_0   = data0_q;
    assign WRITE_DATA_1   = data1_q;
    assign ERROR          = error_q;
    assign CMD_COUNT      = cmd_cnt_q;

endmodule
